adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Pipelined, parametrised successor to the fixed 20-bit ripple adder used by the upscaler datapath.
//  Splits a WIDTH-bit add into ceil(WIDTH/SEG_BITS) registered segments. Carry ripples one segment per cycle.
//  Provides valid/ready flow control, a carry-in and selectable wrap or saturate mode.
//  Sits between the pixel-weight multiplier outputs and the interpolation accumulator.
// PARAMETERS
//  WIDTH     20  operand/result width in bits (>=2)
//  SEG_BITS  5   bits added per pipeline stage (1..WIDTH); STAGES = ceil(WIDTH/SEG_BITS)
//  SAT       0   0 = wrap (carry reported on out_cout); 1 = unsigned saturate to all-ones
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b/cin valid this cycle
//  in_ready   out  1      block accepts an operand set this cycle
//  a          in   WIDTH  operand A, unsigned
//  b          in   WIDTH  operand B, unsigned
//  cin        in   1      carry-in
//  out_valid  out  1      out_sum/out_cout/out_ovf valid
//  out_ready  in   1      downstream accepts result this cycle
//  out_sum    out  WIDTH  (a+b+cin) mod 2^WIDTH, or saturated value when SAT=1
//  out_cout   out  1      carry out of MSB (raw, reported in both modes)
//  out_ovf    out  1      1 when SAT=1 and the result was clamped; always 0 when SAT=0
// BEHAVIOUR
//  - Reset: every stage valid bit = 0. out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0. in_ready = 1 in the cycle after rst deasserts.
//  - Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
//  - Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational, no dependency on in_valid).
//  - When adv=0, every pipeline register holds, including the valid bits. out_* stay stable until accepted.
//  - Stage k (0..STAGES-1) adds segment k of a and b plus the carry from stage k-1 (stage 0 uses cin).
//  - Stage k registers:
//      - its result bits and carry;
//      - the already-computed lower result bits;
//      - the still-unused upper operand bits.
//  - The last segment is WIDTH-(STAGES-1)*SEG_BITS bits wide when WIDTH is not a multiple of SEG_BITS.
//  - Latency: an input accepted at edge N appears with out_valid=1 after edge N+STAGES, provided adv stays 1.
//  - Throughput is one result per cycle. Stalls add latency one-for-one.
//  - Ordering is strict FIFO. No result is dropped or duplicated.
//  - A bubble (in_valid=0) propagates as a valid=0 slot. Bubbles are not collapsed.
//  - SAT=1 and carry out = 1: out_sum = {WIDTH{1'b1}}, out_ovf = 1, out_cout = 1.
//  - SEG_BITS >= WIDTH gives STAGES=1: a single registered add with 1-cycle latency.
//  - Simultaneous output transfer and input transfer in the same cycle is legal and required at full rate.
//  - Reset mid-operation: all in-flight results are discarded, with out_valid=0 in the following cycle.
//    No partially computed value ever appears on out_*.
//  - Inputs a/b/cin are sampled only on input transfer. Their values are don't-care otherwise.
//  - out_* when out_valid=0: hold the last value and must not be relied upon.
// TESTING
//  T1 WIDTH=20,SEG_BITS=5: a=0x00001,b=0x00001,cin=0 at edge 0 -> out_valid at edge 4, out_sum=0x00002, cout=0.
//  T2 full carry ripple, SAT=0: a=0xFFFFF,b=0x00000,cin=1 -> out_sum=0x00000, out_cout=1, out_ovf=0.
//  T3 same stimulus with SAT=1 -> out_sum=0xFFFFF, out_cout=1, out_ovf=1. Also a=0x7FFFF,b=0x80000 -> 0xFFFFF, ovf=0.
//  T4 streaming/backpressure: 16 back-to-back random inputs; out_ready low for 3 cycles mid-stream.
//     -> in_ready low while stalled, out_* stable, all 16 sums in order, each equal to a+b+cin.
//  T5 reset mid-stream: rst high for 1 cycle with 3 results in flight -> out_valid=0 next cycle,
//     no stale result ever emitted; a fresh input afterwards emerges 4 cycles later, correct.
//  T6 WIDTH=24,SEG_BITS=7 (last segment 3 bits): latency 4. 1000 random vectors vs model, both SAT values.
//     Include the corner cases 0+0, max+max and 0x7FFFFF+1.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit unsigned adder with a carry-in. The add is
// split into STAGES = ceil(WIDTH/SEG_BITS) segments, one segment per cycle,
// and the carry moves up one segment per stage. With SAT=1 the result
// saturates to all-ones when the add carries out of the MSB.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (a, b, cin)
//   out_valid / out_ready  result handshake (out_sum, out_cout, out_ovf)
//   out_cout               raw carry out of the MSB, reported in both modes
//   out_ovf                result was clamped (only ever set with SAT=1)
//
// adder_pipe_seg: combinational add of one segment [LO +: W]. Bits outside the
// segment pass through from s_in unchanged.

module adder_pipe_seg #(
  parameter int WIDTH = 20,
  parameter int LO    = 0,
  parameter int W     = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c
);
  logic [W:0] sum;
  // Operand bits outside this segment belong to other stages.
  logic       unused_ops;

  assign unused_ops = ^{a, b};
  assign sum = {1'b0, a[LO+:W]} + {1'b0, b[LO+:W]} + {{W{1'b0}}, c_in};
  assign c   = sum[W];

  always_comb begin
    s          = s_in;
    s[LO+:W]   = sum[W-1:0];
  end
endmodule

module adder_pipe #(
  parameter int WIDTH    = 20,
  parameter int SEG_BITS = 5,
  parameter int SAT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int STAGES = (WIDTH + SEG_BITS - 1) / SEG_BITS;

  // Per-stage inputs (*_in), combinational results (*_nx) and registers (*_q).
  // Stage k sees the operands, partial sum and carry registered by stage k-1;
  // stage 0 sees the module inputs.
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nx;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0]            c_in, c_nx, c_q, v_in;
  logic [STAGES:1]              vld_pipe;
  logic                         adv;
  logic                         sat_hit;
  // Operands held by the last stage are not consumed by anything.
  logic                         unused_regs;

  assign unused_regs = ^{a_q[STAGES-1], b_q[STAGES-1]};

  // Whole pipe advances together; it only blocks when a finished result is
  // waiting on a stalled consumer.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_comb begin
    a_in    = '0;
    b_in    = '0;
    s_in    = '0;
    c_in    = '0;
    v_in    = '0;
    a_in[0] = a;
    b_in[0] = b;
    c_in[0] = cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = vld_pipe[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG_BITS;
    // Final segment may be narrower than SEG_BITS.
    localparam int W  = (WIDTH - LO < SEG_BITS) ? (WIDTH - LO) : SEG_BITS;
    adder_pipe_seg #(.WIDTH(WIDTH), .LO(LO), .W(W)) u_seg (
      .a    (a_in[k]),
      .b    (b_in[k]),
      .s_in (s_in[k]),
      .c_in (c_in[k]),
      .s    (s_nx[k]),
      .c    (c_nx[k])
    );
  end

  // vld_pipe[k+1] tracks the slot held in stage k; bubbles shift through too.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe <= v_in;
    end
  end

  // Data only loads for valid slots, so a bubble leaves the previous
  // contents (and hence out_* during out_valid=0) untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nx[k];
          c_q[k] <= c_nx[k];
        end
      end
    end
  end

  assign sat_hit  = (SAT != 0) && c_q[STAGES-1];
  assign out_cout = c_q[STAGES-1];
  assign out_ovf  = sat_hit;
  assign out_sum  = sat_hit ? {WIDTH{1'b1}} : s_q[STAGES-1];
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe. Four instances share one stimulus stream:
// 20/5 wrap, 20/5 saturate, 24/7 wrap, 24/7 saturate (all four are 4 stages).
// A per-instance queue of expected results is filled on every input transfer
// from an arithmetic model and drained on every output transfer.
module tb_adder_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin;
  logic [23:0] a, b;
  logic [3:0]  rdy, ov, oc, oo;
  logic [19:0] s20 [2];
  logic [23:0] s24 [2];
  logic [23:0] os  [4];

  localparam int WD  [4] = '{20, 20, 24, 24};
  localparam int SATV[4] = '{0, 1, 0, 1};

  int          cmp_n = 0;
  int          err_n = 0;
  logic [25:0] q [4][$];
  logic [31:0] prv [4];
  logic        hold [4];
  logic [31:0] snap [4];
  int          lat [4];

  always #5 clk = ~clk;

  assign os[0] = {4'h0, s20[0]};
  assign os[1] = {4'h0, s20[1]};
  assign os[2] = s24[0];
  assign os[3] = s24[1];

  adder_pipe #(.WIDTH(20), .SEG_BITS(5), .SAT(0)) u_w20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a[19:0]), .b(b[19:0]), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
    .out_sum(s20[0]), .out_cout(oc[0]), .out_ovf(oo[0]));
  adder_pipe #(.WIDTH(20), .SEG_BITS(5), .SAT(1)) u_s20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a[19:0]), .b(b[19:0]), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
    .out_sum(s20[1]), .out_cout(oc[1]), .out_ovf(oo[1]));
  adder_pipe #(.WIDTH(24), .SEG_BITS(7), .SAT(0)) u_w24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
    .out_sum(s24[0]), .out_cout(oc[2]), .out_ovf(oo[2]));
  adder_pipe #(.WIDTH(24), .SEG_BITS(7), .SAT(1)) u_s24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a), .b(b), .cin(cin), .out_valid(ov[3]), .out_ready(out_ready),
    .out_sum(s24[1]), .out_cout(oc[3]), .out_ovf(oo[3]));

  // Expected {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [25:0] model(int w, int sat, logic [23:0] x, logic [23:0] y, logic c);
    longint m    = (longint'(1) << w) - 1;
    longint full = (longint'(x) & m) + (longint'(y) & m) + longint'(c);
    longint s    = full & m;
    logic   co   = ((full >> w) & 1) != 0;
    logic   ovf  = 1'b0;
    if (sat != 0 && co) begin
      s   = m;
      ovf = 1'b1;
    end
    return {ovf, co, s[23:0]};
  endfunction

  function automatic logic [31:0] cur(int i);
    return {5'h0, ov[i], oc[i], oo[i], os[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until it is accepted.
  task automatic send(input logic [23:0] x, input logic [23:0] y, input logic c);
    int  guard = 0;
    logic acc;
    a = x; b = y; cin = c; in_valid = 1'b1;
    do begin
      acc = rdy[0];
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("accept_timeout", 32'(guard), 32'd0);
  endtask

  // Single input, then count edges until each instance shows out_valid.
  task automatic send_timed(input string tag, input logic [23:0] x, input logic [23:0] y, input logic c);
    send(x, y, c);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    for (int n = 1; n <= 8; n++) begin
      for (int i = 0; i < 4; i++) if (ov[i] && lat[i] == 0) lat[i] = n;
      tick();
    end
    for (int i = 0; i < 4; i++) chk($sformatf("%s_latency%0d", tag, i), 32'(lat[i]), 32'd4);
  endtask

  // Single input, check the result after exactly 4 edges against constants.
  task automatic send_const(input string tag, input logic [23:0] x, input logic [23:0] y, input logic c,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    send(x, y, c);
    in_valid = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("%s_%0d", tag, i), cur(i), e[i]);
    tick();
  endtask

  initial begin
    logic [23:0] x, y;
    int          accepted, cyc;
    logic        acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin hold[i] = 1'b0; prv[i] = '0; end

    // Scoreboard / protocol monitor, sampled mid-cycle.
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (rst) begin
            q[i].delete();
            hold[i] = 1'b0;
          end else begin
            chk($sformatf("in_ready%0d", i), {31'h0, rdy[i]}, {31'h0, (!ov[i] || out_ready)});
            if (hold[i]) chk($sformatf("stall_hold%0d", i), cur(i), prv[i]);
            if (ov[i] && out_ready) begin
              if (q[i].size() == 0) chk($sformatf("spurious_out%0d", i), 32'd0, 32'd1);
              else begin
                logic [25:0] e;
                e = q[i].pop_front();
                chk($sformatf("result%0d", i), {6'h0, oo[i], oc[i], os[i]}, {6'h0, e});
              end
            end
            if (in_valid && rdy[i]) q[i].push_back(model(WD[i], SATV[i], a, b, cin));
            hold[i] = ov[i] && !out_ready;
          end
          prv[i] = cur(i);
        end
      end
    join_none

    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("reset_state%0d", i), {4'h0, rdy[i], cur(i)[26:0]}, 32'h0800_0000);

    // T1: 1+1, latency of 4 edges and value 2.
    send_timed("t1", 24'h000001, 24'h000001, 1'b0);

    // T2/T3: carry through every segment; wrap vs saturate.
    send_const("t2", 24'h0FFFFF, 24'h000000, 1'b1,
               32'h0600_0000, 32'h070F_FFFF, 32'h0410_0000, 32'h0410_0000);
    send_const("t3", 24'h07FFFF, 24'h080000, 1'b0,
               32'h040F_FFFF, 32'h040F_FFFF, 32'h040F_FFFF, 32'h040F_FFFF);

    // Corner operands back to back.
    send(24'h000000, 24'h000000, 1'b0);
    send(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    send(24'h7FFFFF, 24'h000001, 1'b0);
    send(24'hFFFFFF, 24'h000000, 1'b1);
    send(24'h0FFFFF, 24'h000001, 1'b0);
    in_valid = 1'b0;
    repeat (6) tick();

    // T4: 16 back-to-back randoms, out_ready low 3 cycles mid-stream.
    for (int k = 0; k < 16; k++) begin
      x = 24'($urandom); y = 24'($urandom);
      a = x; b = y; cin = 1'($urandom); in_valid = 1'b1;
      if (k == 8) begin
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) snap[i] = cur(i);
        for (int j = 0; j < 3; j++) begin
          tick();
          chk($sformatf("t4_in_ready_low%0d", j), {28'h0, rdy}, 32'h0);
          for (int i = 0; i < 4; i++) chk($sformatf("t4_out_stable%0d", i), cur(i), snap[i]);
        end
        out_ready = 1'b1;
      end
      send(x, y, cin);
    end
    in_valid = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("t4_drained%0d", i), 32'(q[i].size()), 32'd0);

    // T5: reset with 3 results in flight.
    for (int k = 0; k < 3; k++) send(24'($urandom), 24'($urandom), 1'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid_after_rst", {28'h0, ov}, 32'h0);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("t5_no_stale%0d", j), {28'h0, ov}, 32'h0);
    end
    send_timed("t5", 24'($urandom), 24'($urandom), 1'b1);

    // T6: random valid/ready traffic until 1000 operand sets are accepted.
    accepted = 0;
    cyc      = 0;
    while (accepted < 1000 && cyc < 5000) begin
      case ($urandom % 8)
        0: x = 24'h000000;
        1: x = 24'hFFFFFF;
        default: x = 24'($urandom);
      endcase
      case ($urandom % 8)
        0: y = 24'h000000;
        1: y = 24'hFFFFFF;
        default: y = 24'($urandom);
      endcase
      a = x; b = y; cin = 1'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      #1;
      acc = in_valid && rdy[0];
      tick();
      if (acc) accepted++;
      cyc++;
    end
    chk("t6_accepted", 32'(accepted), 32'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("t6_drained%0d", i), 32'(q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
